// File: rtl/mult_8x8_seq_ctrl_pkg.sv
// Shared types and constants for the time-shared 8x8 multiplier.
// The state enum, quadrant ids and per-quadrant shift amounts.
package mult_8x8_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] Q_LL = 2'd0;
  localparam logic [1:0] Q_LH = 2'd1;
  localparam logic [1:0] Q_HL = 2'd2;
  localparam logic [1:0] Q_HH = 2'd3;

  localparam logic [3:0] SHIFT_TBL [4] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [3:0] quad_shift(input logic [1:0] q);
    return SHIFT_TBL[q];
  endfunction

endpackage

// File: rtl/mult_8x8_seq_ctrl_quad_acc.sv
// Nibble select toward the shared 4x4 core plus shift-and-accumulate.
// PIPE_MUL=1 accumulates the quadrant issued one cycle earlier.
module mult_quad_acc
  import mult_8x8_seq_ctrl_pkg::*;
#(
  parameter int PIPE_MUL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        issue,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [1:0]  quad,
  input  logic [7:0]  mul_p,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_q,
  output logic [15:0] acc
);

  localparam bit PIPE = (PIPE_MUL != 0);

  logic [15:0] acc_q, acc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [3:0]  pend_sh_q, pend_sh_d;
  logic        add_en;
  logic [3:0]  add_sh;

  // Operand nibbles for the current quadrant; zero when not issuing.
  always_comb begin
    mul_a = 4'd0;
    mul_b = 4'd0;
    mul_q = 2'd0;
    if (issue) begin
      mul_a = quad[1] ? op_a[7:4] : op_a[3:0];
      mul_b = quad[0] ? op_b[7:4] : op_b[3:0];
      mul_q = quad;
    end
  end

  // Pick which product lands this cycle and accumulate it.
  always_comb begin
    pend_vld_d = issue;
    pend_sh_d  = quad_shift(quad);
    add_en     = PIPE ? pend_vld_q : issue;
    add_sh     = PIPE ? pend_sh_q : quad_shift(quad);
    acc_d      = acc_q;
    if (clr) begin
      acc_d      = 16'd0;
      pend_vld_d = 1'b0;
    end else if (add_en) begin
      acc_d = acc_q + ({8'h00, mul_p} << add_sh);
    end
  end

  // Accumulator and pipeline-alignment registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= 16'd0;
      pend_vld_q <= 1'b0;
      pend_sh_q  <= 4'd0;
    end else begin
      acc_q      <= acc_d;
      pend_vld_q <= pend_vld_d;
      pend_sh_q  <= pend_sh_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// 8x8 unsigned multiply built from four passes through one 4x4 core.
// Owns the FSM and the valid/ready handshakes.
module mult_8x8_seq_ctrl
  import mult_8x8_seq_ctrl_pkg::*;
#(
  parameter int PIPE_MUL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_q,
  input  logic [7:0]  mul_p
);

  localparam bit PIPE = (PIPE_MUL != 0);

  state_e      state_q, state_d;
  logic [7:0]  op_a_q, op_a_d;
  logic [7:0]  op_b_q, op_b_d;
  logic [1:0]  quad_q, quad_d;
  logic        issue;
  logic        clr;
  logic [15:0] acc;

  // Next-state, operand capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    quad_d    = quad_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    clr       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          quad_d  = Q_LL;
          clr     = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        issue  = 1'b1;
        quad_d = quad_q + 2'd1;
        if (quad_q == Q_HH) begin
          state_d = PIPE ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= 8'd0;
      op_b_q  <= 8'd0;
      quad_q  <= Q_LL;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      quad_q  <= quad_d;
    end
  end

  mult_quad_acc #(
    .PIPE_MUL(PIPE_MUL)
  ) u_quad_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .issue (issue),
    .op_a  (op_a_q),
    .op_b  (op_b_q),
    .quad  (quad_q),
    .mul_p (mul_p),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_q (mul_q),
    .acc   (acc)
  );

  assign out_r = out_valid ? acc : 16'd0;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Bench for mult_8x8_seq_ctrl: one combinational-core and one
// pipelined-core instance share stimulus; each has its own 4x4 stub.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic        out_ready;
  logic        const_mode;

  logic        in_ready0, out_valid0, busy0;
  logic [15:0] out_r0;
  logic [3:0]  mul_a0, mul_b0;
  logic [1:0]  mul_q0;
  logic [7:0]  mul_p0;

  logic        in_ready1, out_valid1, busy1;
  logic [15:0] out_r1;
  logic [3:0]  mul_a1, mul_b1;
  logic [1:0]  mul_q1;
  logic [7:0]  mul_p1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_8x8_seq_ctrl #(.PIPE_MUL(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_r(out_r0), .busy(busy0),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_q(mul_q0),
    .mul_p(mul_p0)
  );

  mult_8x8_seq_ctrl #(.PIPE_MUL(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_r(out_r1), .busy(busy1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_q(mul_q1),
    .mul_p(mul_p1)
  );

  // Exact or constant 4x4 stubs: combinational and one-stage registered.
  assign mul_p0 = const_mode ? 8'hFF : ({4'h0, mul_a0} * {4'h0, mul_b0});

  always_ff @(posedge clk) begin
    mul_p1 <= const_mode ? 8'hFF : ({4'h0, mul_a1} * {4'h0, mul_b1});
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op to both instances with out_ready high; returns results
  // and latencies (edges from the accept edge, inclusive).
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r0, output logic [15:0] r1,
                       output int l0, output int l1);
    bit g0, g1;
    int cnt;
    r0 = 16'd0; r1 = 16'd0; l0 = -1; l1 = -1; g0 = 0; g1 = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt = 1;
    while (!(g0 && g1) && cnt < 20) begin
      if (!g0 && out_valid0) begin g0 = 1; r0 = out_r0; l0 = cnt; end
      if (!g1 && out_valid1) begin g1 = 1; r1 = out_r1; l1 = cnt; end
      if (!(g0 && g1)) begin step(); cnt++; end
    end
    step();
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          cst;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  logic [3:0] seq_a [4];
  logic [3:0] seq_b [4];

  initial begin
    logic [15:0] r0, r1;
    int l0, l1, cnt, seen;
    int acc0 [$];
    int acc1 [$];

    vecs[0] = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[2] = '{8'h5A, 8'hC3, 1'b1, 16'h1FDF};
    vecs[3] = '{8'h00, 8'hAB, 1'b0, 16'h0000};
    vecs[4] = '{8'h0F, 8'h10, 1'b0, 16'h00F0};
    vecs[5] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[6] = '{8'hC8, 8'h64, 1'b0, 16'h4E20};
    vecs[7] = '{8'h01, 8'hFF, 1'b0, 16'h00FF};
    seq_a = '{4'h2, 4'h2, 4'h1, 4'h1};
    seq_b = '{4'h4, 4'h3, 4'h4, 4'h3};

    rst = 1'b1; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0;
    out_ready = 1'b1; const_mode = 1'b0;
    step(); step();
    chk("rst_in_ready", int'(in_ready0), 1);
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_r", int'(out_r0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_mul", int'({mul_a0, mul_b0, mul_q0}), 0);
    chk("rst_busy1", int'(busy1), 0);
    rst = 1'b0;
    step();

    // Quadrant issue order for A=0x12, B=0x34.
    in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq0_q%0d", i), int'({mul_a0, mul_b0, mul_q0}),
          int'({seq_a[i], seq_b[i], 2'(i)}));
      chk($sformatf("seq1_q%0d", i), int'({mul_a1, mul_b1, mul_q1}),
          int'({seq_a[i], seq_b[i], 2'(i)}));
      step();
    end
    chk("seq0_done_valid", int'(out_valid0), 1);
    chk("seq0_done_r", int'(out_r0), 16'h03A8);
    chk("seq0_done_mul", int'({mul_a0, mul_b0, mul_q0}), 0);
    chk("seq1_drain_mul", int'({mul_a1, mul_b1, mul_q1}), 0);
    chk("seq1_drain_valid", int'(out_valid1), 0);
    step();
    chk("seq1_done_valid", int'(out_valid1), 1);
    chk("seq1_done_r", int'(out_r1), 16'h03A8);
    step();

    // Directed vector table.
    foreach (vecs[i]) begin
      const_mode = vecs[i].cst;
      do_op(vecs[i].a, vecs[i].b, r0, r1, l0, l1);
      const_mode = 1'b0;
      chk($sformatf("vec%0d_r0", i), int'(r0), int'(vecs[i].exp));
      chk($sformatf("vec%0d_r1", i), int'(r1), int'(vecs[i].exp));
      chk($sformatf("vec%0d_lat0", i), l0, 5);
      chk($sformatf("vec%0d_lat1", i), l1, 6);
    end

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    in_a = 8'h0F; in_b = 8'h10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid0 && cnt < 20) begin step(); cnt++; end
    chk("bp_lat0", cnt, 5);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_r0_%0d", i), int'(out_r0), 16'h00F0);
      chk($sformatf("bp_ready0_%0d", i), int'(in_ready0), 0);
      chk($sformatf("bp_valid0_%0d", i), int'(out_valid0), 1);
      in_valid = 1'b1; in_a = 8'h77; in_b = 8'h99;
      step();
      in_valid = 1'b0;
    end
    chk("bp_r0_end", int'(out_r0), 16'h00F0);
    chk("bp_valid1", int'(out_valid1), 1);
    chk("bp_r1", int'(out_r1), 16'h00F0);
    chk("bp_ready1", int'(in_ready1), 0);
    out_ready = 1'b1;
    step();
    chk("bp_after_ready0", int'(in_ready0), 1);
    chk("bp_after_ready1", int'(in_ready1), 1);
    chk("bp_after_valid0", int'(out_valid0), 0);

    // Back-to-back throughput with in_valid held high.
    in_a = 8'h03; in_b = 8'h05; in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (in_ready0) acc0.push_back(k);
      if (in_ready1) acc1.push_back(k);
      step();
    end
    in_valid = 1'b0;
    chk("tput0", (acc0.size() >= 2) ? acc0[1] - acc0[0] : -1, 6);
    chk("tput1", (acc1.size() >= 2) ? acc1[1] - acc1[0] : -1, 7);
    cnt = 0;
    while (!(in_ready0 && in_ready1) && cnt < 20) begin step(); cnt++; end
    chk("tput_idle", int'(in_ready0 && in_ready1), 1);

    // Reset while in CALC at quadrant 2.
    in_a = 8'hAB; in_b = 8'hCD; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("mr_at_q2", int'(mul_q0), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy0", int'(busy0), 0);
    chk("mr_ready0", int'(in_ready0), 1);
    chk("mr_valid0", int'(out_valid0), 0);
    chk("mr_mul0", int'({mul_a0, mul_b0, mul_q0}), 0);
    chk("mr_busy1", int'(busy1), 0);
    chk("mr_mul1", int'({mul_a1, mul_b1, mul_q1}), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid0 || out_valid1) seen++;
      step();
    end
    chk("mr_no_result", seen, 0);
    do_op(8'h03, 8'h05, r0, r1, l0, l1);
    chk("mr_next_r0", int'(r0), 16'h000F);
    chk("mr_next_r1", int'(r1), 16'h000F);
    chk("mr_next_lat0", l0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
